enigma_cmd_seq: RTL and testbench
=================================

// Module: enigma_cmd_seq
// PURPOSE
//  Consumer of the validated, debounced letter/button levels from the input-validation stage.
//  Converts button levels into one-cycle commands for the cipher datapath:
//   - plugboard pair writes (two LDPLUG presses)
//   - rotor start-position loads (three LDROT presses)
//   - encrypt requests (ENTER, req/ack handshake to the cipher core)
//  Sits between the input-validation stage and the plugboard/rotor/cipher registers.
// PARAMETERS
//  TIMEOUT_CYC  500_000_000  idle cycles allowed in a partial plug/rotor sequence before abort (5 s @100 MHz)
// PORTS
//  CLK      in   1  system clock, all logic on rising edge
//  RST      in   1  asynchronous, active-high reset
//  LET      in   5  validated letter 0..25
//  ENTER    in   1  validated debounced ENTER level
//  LDPLUG   in   1  validated debounced plugboard-load level
//  LDROT    in   1  validated debounced rotor-load level
//  PLUG_WE  out  1  one-cycle plugboard write strobe
//  PLUG_A   out  5  first letter of pair; valid when PLUG_WE=1
//  PLUG_B   out  5  second letter of pair; valid when PLUG_WE=1
//  ROT_WE   out  1  one-cycle rotor position write strobe
//  ROT_IDX  out  2  rotor index 0..2; valid when ROT_WE=1
//  ROT_POS  out  5  rotor start letter; valid when ROT_WE=1
//  ENC_REQ  out  1  encrypt request, held until acknowledged
//  ENC_LET  out  5  letter to encrypt; stable while ENC_REQ=1
//  ENC_ACK  in   1  cipher core accepts ENC_LET
//  ABORT    out  1  one-cycle pulse: partial sequence timed out
//  BUSY     out  1  1 in any state other than IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; timeout counter 0.
//  - Reset: edge-detector history regs set to 1, so a button held through reset is not a press.
//  - Press: level=1 and prev=0.
//  - More than one press in the same cycle: all ignored, no state change.
//  - All outputs are registered. A press sampled at edge n produces its response at edge n+1.
//  - IDLE:
//     - LDPLUG press: latch LET into PLUG_A; go to PLUG2.
//     - LDROT press: ROT_WE=1, ROT_IDX=0, ROT_POS=LET; go to ROT1.
//     - ENTER press: ENC_REQ=1, ENC_LET=LET; go to ENCW.
//  - PLUG2:
//     - LDPLUG press, LET!=PLUG_A: PLUG_WE=1 with (PLUG_A, LET); go to IDLE.
//     - LDPLUG press, LET==PLUG_A: cancel, no write, no ABORT; go to IDLE.
//     - ENTER and LDROT presses are dropped.
//  - ROT1 / ROT2:
//     - LDROT press writes ROT_IDX=1 / ROT_IDX=2 with ROT_POS=LET.
//     - Next state is ROT2 / IDLE.
//     - Other presses are dropped.
//  - Timeout:
//     - Counter counts cycles in PLUG2, ROT1 and ROT2; cleared on every state change.
//     - Reaching TIMEOUT_CYC-1: ABORT pulse, go to IDLE.
//     - Rotors already written keep their values; a pending PLUG_A is discarded.
//  - ENCW:
//     - ENC_REQ and ENC_LET held stable.
//     - Edge where ENC_ACK=1: ENC_REQ=0 next cycle; go to IDLE.
//     - All presses while in ENCW are dropped, not queued.
//     - No timeout in ENCW.
//     - ENC_ACK outside ENCW is ignored.
//  - Reset asserted mid-sequence or mid-handshake:
//     - Immediate return to reset values.
//     - ENC_REQ drops asynchronously.
//     - No partial writes are issued.
//  - Strobes PLUG_WE, ROT_WE and ABORT are never high together and never high for two consecutive cycles.
// STRUCTURE
//  - enigma_pkg:
//     - typedef logic [4:0] letter_t
//     - NUM_LETTERS=26, NUM_ROTORS=3
//     - typedef enum {IDLE, PLUG2, ROT1, ROT2, ENCW} cmd_state_t
//  - Sub-module rise_detect:
//     - One instance per button.
//     - Resets history to 1 on RST.
//     - Outputs a one-cycle press.
//  - enigma_cmd_seq: FSM, timeout counter, output registers.
// TESTING
//  1. LDPLUG press with LET=3, then LDPLUG press with LET=17
//     -> single PLUG_WE pulse, PLUG_A=3, PLUG_B=17; BUSY high between presses.
//  2. LDROT presses with LET=0, 12, 25
//     -> three ROT_WE pulses: (IDX 0, POS 0), (1, 12), (2, 25); BUSY=0 after the third.
//  3. ENTER with LET=7; hold ENC_ACK=0 for 10 cycles, then 1 for one cycle
//     -> ENC_REQ=1 and ENC_LET=7 for all 11 cycles; ENC_REQ=0 on the following cycle.
//     -> a second ENTER during the wait produces nothing.
//  4. TIMEOUT_CYC=16: one LDROT press, then idle
//     -> ROT_WE for IDX 0; ABORT pulse 16 cycles later; next LDROT press writes IDX 0 again.
//  5. LDPLUG LET=5 twice -> no PLUG_WE, no ABORT, BUSY=0.
//     -> ENTER and LDPLUG rising on the same edge: ignored, state unchanged.
//  6. ENTER held high across RST deassertion -> no ENC_REQ.
//     -> RST asserted during ENCW -> ENC_REQ=0 immediately, state IDLE.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types for the Enigma command path: letter encoding, machine
// dimensions and the command sequencer state set.
package enigma_pkg;

  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned NUM_ROTORS  = 3;

  typedef logic [$clog2(NUM_LETTERS)-1:0] letter_t;

  typedef enum logic [2:0] {
    IDLE,
    PLUG2,
    ROT1,
    ROT2,
    ENCW
  } cmd_state_t;

endpackage

// File: rtl/enigma_cmd_seq_rise_detect.sv
// Registered rising-edge detector for one debounced button level.
// History resets to 1 so a button already held at reset release is not a press.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press
);

  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= 1'b1;
      press <= 1'b0;
    end else begin
      prev  <= level;
      press <= level & ~prev;
    end
  end

endmodule

// File: rtl/enigma_cmd_seq.sv
// Turns debounced button levels into one-cycle plugboard/rotor write strobes
// and a held encrypt request with req/ack handshake to the cipher core.
module enigma_cmd_seq
  import enigma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500_000_000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  letter_t                       LET,
  input  logic                          ENTER,
  input  logic                          LDPLUG,
  input  logic                          LDROT,
  output logic                          PLUG_WE,
  output letter_t                       PLUG_A,
  output letter_t                       PLUG_B,
  output logic                          ROT_WE,
  output logic [$clog2(NUM_ROTORS)-1:0] ROT_IDX,
  output letter_t                       ROT_POS,
  output logic                          ENC_REQ,
  output letter_t                       ENC_LET,
  input  logic                          ENC_ACK,
  output logic                          ABORT,
  output logic                          BUSY
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  cmd_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic press_ent, press_plug, press_rot;
  logic p_ent, p_plug, p_rot, timeout_hit;

  logic                          plug_we_d, rot_we_d, abort_d, enc_req_d;
  letter_t                       plug_a_d, plug_b_d, rot_pos_d, enc_let_d;
  logic [$clog2(NUM_ROTORS)-1:0] rot_idx_d;

  rise_detect u_rd_ent  (.clk(CLK), .rst(RST), .level(ENTER),  .press(press_ent));
  rise_detect u_rd_plug (.clk(CLK), .rst(RST), .level(LDPLUG), .press(press_plug));
  rise_detect u_rd_rot  (.clk(CLK), .rst(RST), .level(LDROT),  .press(press_rot));

  // Simultaneous presses are ambiguous and all get discarded.
  assign p_ent  = press_ent  & ~press_plug & ~press_rot;
  assign p_plug = press_plug & ~press_ent  & ~press_rot;
  assign p_rot  = press_rot  & ~press_ent  & ~press_plug;

  assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      BUSY  <= 1'b0;
    end else begin
      state <= state_n;
      BUSY  <= (state_n != IDLE);
      if ((state_n != state) || !(state inside {PLUG2, ROT1, ROT2}))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (p_plug)     state_n = PLUG2;
        else if (p_rot) state_n = ROT1;
        else if (p_ent) state_n = ENCW;
      end
      PLUG2:   if (p_plug || timeout_hit) state_n = IDLE;
      ROT1: begin
        if (p_rot)            state_n = ROT2;
        else if (timeout_hit) state_n = IDLE;
      end
      ROT2:    if (p_rot || timeout_hit) state_n = IDLE;
      ENCW:    if (ENC_ACK) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    plug_we_d = 1'b0;
    rot_we_d  = 1'b0;
    abort_d   = 1'b0;
    plug_a_d  = PLUG_A;
    plug_b_d  = PLUG_B;
    rot_idx_d = ROT_IDX;
    rot_pos_d = ROT_POS;
    enc_req_d = ENC_REQ;
    enc_let_d = ENC_LET;
    case (state)
      IDLE: begin
        if (p_plug) begin
          plug_a_d = LET;
        end else if (p_rot) begin
          rot_we_d  = 1'b1;
          rot_idx_d = 2'd0;
          rot_pos_d = LET;
        end else if (p_ent) begin
          enc_req_d = 1'b1;
          enc_let_d = LET;
        end
      end
      PLUG2: begin
        if (p_plug) begin
          if (LET != PLUG_A) begin
            plug_we_d = 1'b1;
            plug_b_d  = LET;
          end
        end else if (timeout_hit) begin
          abort_d = 1'b1;
        end
      end
      ROT1, ROT2: begin
        if (p_rot) begin
          rot_we_d  = 1'b1;
          rot_idx_d = (state == ROT1) ? 2'd1 : 2'd2;
          rot_pos_d = LET;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
        end
      end
      ENCW:    if (ENC_ACK) enc_req_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PLUG_WE <= 1'b0;
      PLUG_A  <= '0;
      PLUG_B  <= '0;
      ROT_WE  <= 1'b0;
      ROT_IDX <= '0;
      ROT_POS <= '0;
      ENC_REQ <= 1'b0;
      ENC_LET <= '0;
      ABORT   <= 1'b0;
    end else begin
      PLUG_WE <= plug_we_d;
      PLUG_A  <= plug_a_d;
      PLUG_B  <= plug_b_d;
      ROT_WE  <= rot_we_d;
      ROT_IDX <= rot_idx_d;
      ROT_POS <= rot_pos_d;
      ENC_REQ <= enc_req_d;
      ENC_LET <= enc_let_d;
      ABORT   <= abort_d;
    end
  end

endmodule

// File: tb/tb_enigma_cmd_seq.sv
// Self-checking bench for enigma_cmd_seq: table of button presses with an
// event scoreboard, plus hand-written handshake, timeout and reset sequences.
module tb_enigma_cmd_seq;
  import enigma_pkg::*;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        RST, ENTER, LDPLUG, LDROT, ENC_ACK;
  letter_t     LET;
  logic        PLUG_WE, ROT_WE, ENC_REQ, ABORT, BUSY;
  letter_t     PLUG_A, PLUG_B, ROT_POS, ENC_LET;
  logic [1:0]  ROT_IDX;

  always #5 CLK = ~CLK;

  enigma_cmd_seq #(.TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .LET(LET), .ENTER(ENTER), .LDPLUG(LDPLUG), .LDROT(LDROT),
    .PLUG_WE(PLUG_WE), .PLUG_A(PLUG_A), .PLUG_B(PLUG_B),
    .ROT_WE(ROT_WE), .ROT_IDX(ROT_IDX), .ROT_POS(ROT_POS),
    .ENC_REQ(ENC_REQ), .ENC_LET(ENC_LET), .ENC_ACK(ENC_ACK),
    .ABORT(ABORT), .BUSY(BUSY)
  );

  typedef enum int {EV_NONE, EV_PLUG, EV_ROT, EV_ENC, EV_ABORT} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [4:0] a; logic [4:0] b; } ev_t;
  // btn: 0=LDPLUG 1=LDROT 2=ENTER 3=LDPLUG+ENTER together
  typedef struct { int btn; letter_t l; ev_kind_t kind; logic [4:0] a; logic [4:0] b; logic busy; } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic void push(input ev_kind_t k, input logic [4:0] a, input logic [4:0] b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  task automatic take_event(input ev_kind_t k, input logic [4:0] a, input logic [4:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d a=%0d b=%0d, required none", k, a, b);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k != EV_ABORT) check("event_a", a, e.a);
      if (k == EV_PLUG || k == EV_ROT) check("event_b", b, e.b);
    end
  endtask

  // Output monitor: every strobe / request rise must match the scoreboard head.
  int unsigned cyc = 0, rot_cyc = 0, abort_cyc = 0, n_abort = 0;
  logic        req_prev = 1'b0;
  logic [2:0]  strobes, strobe_prev = 3'b000;
  letter_t     enc_held = '0;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      req_prev    = 1'b0;
      strobe_prev = 3'b000;
    end else begin
      strobes = {PLUG_WE, ROT_WE, ABORT};
      if (strobes != 3'b000)
        check("strobe_exclusive", {31'd0, ($onehot(strobes) && strobe_prev == 3'b000)}, 32'd1);
      if (PLUG_WE) take_event(EV_PLUG, PLUG_A, PLUG_B);
      if (ROT_WE) begin
        take_event(EV_ROT, {3'b000, ROT_IDX}, ROT_POS);
        rot_cyc = cyc;
      end
      if (ABORT) begin
        take_event(EV_ABORT, 5'd0, 5'd0);
        abort_cyc = cyc;
        n_abort++;
      end
      if (ENC_REQ && !req_prev) begin
        take_event(EV_ENC, ENC_LET, 5'd0);
        enc_held = ENC_LET;
      end else if (ENC_REQ) begin
        check("enc_let_stable", ENC_LET, enc_held);
      end
      req_prev    = ENC_REQ;
      strobe_prev = strobes;
    end
  end

  task automatic press(input int btn, input letter_t l);
    @(negedge CLK);
    LET = l;
    case (btn)
      0: LDPLUG = 1'b1;
      1: LDROT  = 1'b1;
      2: ENTER  = 1'b1;
      default: begin LDPLUG = 1'b1; ENTER = 1'b1; end
    endcase
    repeat (2) @(negedge CLK);
    LDPLUG = 1'b0; LDROT = 1'b0; ENTER = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_abort(input string name);
    int unsigned n0;
    n0 = n_abort;
    for (int k = 0; k < 40 && n_abort == n0; k++) @(negedge CLK);
    @(negedge CLK);
    check(name, n_abort, n0 + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{0, 5'd3,  EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{0, 5'd17, EV_PLUG, 5'd3, 5'd17, 1'b0});
    vecs.push_back('{1, 5'd0,  EV_ROT,  5'd0, 5'd0,  1'b1});
    vecs.push_back('{1, 5'd12, EV_ROT,  5'd1, 5'd12, 1'b1});
    vecs.push_back('{1, 5'd25, EV_ROT,  5'd2, 5'd25, 1'b0});
    vecs.push_back('{0, 5'd5,  EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{0, 5'd5,  EV_NONE, 5'd0, 5'd0,  1'b0});
    vecs.push_back('{0, 5'd9,  EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{1, 5'd4,  EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{2, 5'd4,  EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{0, 5'd1,  EV_PLUG, 5'd9, 5'd1,  1'b0});
    vecs.push_back('{3, 5'd10, EV_NONE, 5'd0, 5'd0,  1'b0});
    vecs.push_back('{0, 5'd25, EV_NONE, 5'd0, 5'd0,  1'b1});
    vecs.push_back('{0, 5'd0,  EV_PLUG, 5'd25, 5'd0, 1'b0});

    RST = 1'b1; ENTER = 1'b0; LDPLUG = 1'b0; LDROT = 1'b0; ENC_ACK = 1'b0; LET = '0;
    repeat (3) @(negedge CLK);
    check("rst_outputs", {PLUG_WE, ROT_WE, ENC_REQ, ABORT, BUSY}, 0);
    check("rst_data", {PLUG_A, PLUG_B, ROT_POS, ENC_LET, ROT_IDX}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    foreach (vecs[i]) begin
      if (vecs[i].kind != EV_NONE) push(vecs[i].kind, vecs[i].a, vecs[i].b);
      press(vecs[i].btn, vecs[i].l);
      check($sformatf("vec%0d_busy", i), BUSY, vecs[i].busy);
      check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
    end

    // Encrypt handshake: request held for ten ack-less cycles, second ENTER dropped.
    push(EV_ENC, 5'd7, 5'd0);
    press(2, 5'd7);
    check("enc_req_up", ENC_REQ, 1);
    for (int i = 0; i < 10; i++) begin
      ENTER = (i >= 2 && i < 4);
      LET   = (i >= 2) ? 5'd2 : 5'd7;
      @(negedge CLK);
      check("enc_req_held", ENC_REQ, 1);
      check("enc_let_held", ENC_LET, 7);
    end
    ENC_ACK = 1'b1;
    @(negedge CLK);
    ENC_ACK = 1'b0;
    check("enc_req_dropped", ENC_REQ, 0);
    check("enc_idle_busy", BUSY, 0);
    repeat (4) @(negedge CLK);
    check("enc_no_repeat", exp_q.size(), 0);

    // Stray ack in IDLE has no effect.
    ENC_ACK = 1'b1;
    repeat (2) @(negedge CLK);
    ENC_ACK = 1'b0;
    check("stray_ack_req", ENC_REQ, 0);
    check("stray_ack_busy", BUSY, 0);

    // Rotor sequence timeout and restart from index 0.
    push(EV_ROT, 5'd0, 5'd8);
    push(EV_ABORT, 5'd0, 5'd0);
    press(1, 5'd8);
    wait_abort("rot_abort_seen");
    check("rot_abort_delay", abort_cyc - rot_cyc, TO);
    check("rot_abort_busy", BUSY, 0);
    push(EV_ROT, 5'd0, 5'd20);
    push(EV_ROT, 5'd1, 5'd21);
    push(EV_ROT, 5'd2, 5'd22);
    press(1, 5'd20);
    press(1, 5'd21);
    press(1, 5'd22);
    check("rot_restart_drained", exp_q.size(), 0);
    check("rot_restart_busy", BUSY, 0);

    // Plug timeout discards the pending first letter.
    push(EV_ABORT, 5'd0, 5'd0);
    press(0, 5'd4);
    wait_abort("plug_abort_seen");
    push(EV_PLUG, 5'd6, 5'd4);
    press(0, 5'd6);
    press(0, 5'd4);
    check("plug_after_abort", exp_q.size(), 0);

    // ENTER held through reset release is not a press.
    @(negedge CLK);
    RST = 1'b1; ENTER = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (4) @(negedge CLK);
    ENTER = 1'b0;
    repeat (3) @(negedge CLK);
    check("held_enter_req", ENC_REQ, 0);
    check("held_enter_busy", BUSY, 0);

    // Reset mid-handshake drops the request without waiting for a clock edge.
    push(EV_ENC, 5'd11, 5'd0);
    press(2, 5'd11);
    check("enc2_req_up", ENC_REQ, 1);
    #2 RST = 1'b1;
    #1;
    check("async_req_drop", ENC_REQ, 0);
    check("async_busy_drop", BUSY, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("post_rst_req", ENC_REQ, 0);
    push(EV_PLUG, 5'd1, 5'd2);
    press(0, 5'd1);
    check("post_rst_busy", BUSY, 1);
    press(0, 5'd2);
    repeat (3) @(negedge CLK);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
